// File: rtl/sobel_ci_pkg.sv
// Shared types and helpers for the Sobel custom-instruction initiator:
// FSM state encoding, 3x3 window slot indices, operand packing and magnitude saturation.
package sobel_ci_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT
  } ci_state_e;

  // Window slots: top row L->R, mid-left, mid-right, bottom row L->R (centre unused)
  localparam int unsigned WIN_P0 = 0;
  localparam int unsigned WIN_P1 = 1;
  localparam int unsigned WIN_P2 = 2;
  localparam int unsigned WIN_P3 = 3;
  localparam int unsigned WIN_P4 = 4;
  localparam int unsigned WIN_P5 = 5;
  localparam int unsigned WIN_P6 = 6;
  localparam int unsigned WIN_P7 = 7;

  typedef logic [7:0][7:0] window_t;

  typedef struct packed {
    logic [31:0] value_a;
    logic [31:0] value_b;
  } ci_operands_t;

  function automatic ci_operands_t pack_window(input window_t w);
    ci_operands_t ops;
    ops.value_a = {w[WIN_P0], w[WIN_P1], w[WIN_P2], w[WIN_P3]};
    ops.value_b = {w[WIN_P4], w[WIN_P5], w[WIN_P6], w[WIN_P7]};
    return ops;
  endfunction

  function automatic logic [7:0] saturate_mag(input logic [15:0] mag);
    return (mag > 16'd255) ? 8'hFF : mag[7:0];
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One line of 8-bit pixels; the read port returns the old contents of addr
// in the same cycle that a write to addr is committed (read-before-write).
module sobel_line_buffer #(
  parameter int unsigned DEPTH = 640,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/sobel_ci_initiator.sv
// CPU-side custom-instruction initiator for Sobel offload: windows a raster pixel
// stream, issues one CI call per interior pixel and streams back the magnitude.
// Optional SOBEL_CI_THRESHOLD_EN adds a threshold port and binarises the output.
module sobel_ci_initiator
  import sobel_ci_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = 640,
  parameter logic [7:0]  CUSTOM_ID  = 8'h00,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        sof,
  input  logic        inValid,
  input  logic [7:0]  inPixel,
  output logic        inReady,
  output logic        ciStart,
  output logic [7:0]  ciN,
  output logic [31:0] ciValueA,
  output logic [31:0] ciValueB,
  input  logic        ciDone,
  input  logic [31:0] ciResult,
  output logic        outValid,
  output logic [7:0]  outPixel,
  input  logic        outReady,
`ifdef SOBEL_CI_THRESHOLD_EN
  input  logic [7:0]  threshold,
`endif
  output logic        ciError
);

  localparam int unsigned AW = $clog2(LINE_WIDTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  ci_state_e state_q, state_d;

  logic          run_q;
  logic [AW-1:0] col_q, cur_col;
  logic [1:0]    row_q, cur_row;
  logic          accept, issue_hit, capture, timeout;
  logic [7:0]    rd_mid, rd_top;
  logic [7:0]    top_l, top_m, mid_l, mid_m, bot_l, bot_m;
  logic [31:0]   ci_a_q, ci_b_q;
  logic [TW-1:0] wait_cnt;
  logic [7:0]    out_q, result_pixel;
  logic          err_q;
  window_t       win;
  ci_operands_t  ops;
  logic          unused_result_hi;

  assign unused_result_hi = ^ciResult[31:16];

  assign inReady  = run_q && (state_q == IDLE);
  assign ciN      = CUSTOM_ID;
  assign ciValueA = ci_a_q;
  assign ciValueB = ci_b_q;
  assign outPixel = out_q;
  assign ciError  = err_q;

  assign accept  = inValid && inReady;
  assign cur_col = sof ? '0 : col_q;
  assign cur_row = sof ? '0 : row_q;
  // row counter saturates at 2: only "at least two rows above" matters
  assign issue_hit = (cur_row == 2'd2) && (cur_col >= AW'(2));

  // lb_mid holds the previous line, lb_top the one before; lb_top is refilled from lb_mid
  sobel_line_buffer #(.DEPTH(LINE_WIDTH)) u_lb_mid (
    .clock (clock),
    .we    (accept),
    .addr  (cur_col),
    .wdata (inPixel),
    .rdata (rd_mid)
  );

  sobel_line_buffer #(.DEPTH(LINE_WIDTH)) u_lb_top (
    .clock (clock),
    .we    (accept),
    .addr  (cur_col),
    .wdata (rd_mid),
    .rdata (rd_top)
  );

  // Window as it will look after the shift; right column comes straight from the buffers
  always_comb begin
    win         = '0;
    win[WIN_P0] = top_l;
    win[WIN_P1] = top_m;
    win[WIN_P2] = rd_top;
    win[WIN_P3] = mid_l;
    win[WIN_P4] = rd_mid;
    win[WIN_P5] = bot_l;
    win[WIN_P6] = bot_m;
    win[WIN_P7] = inPixel;
    ops         = pack_window(win);
  end

`ifdef SOBEL_CI_THRESHOLD_EN
  assign result_pixel = (saturate_mag(ciResult[15:0]) > threshold) ? 8'hFF : 8'h00;
`else
  assign result_pixel = saturate_mag(ciResult[15:0]);
`endif

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ciStart  = 1'b0;
    outValid = 1'b0;
    capture  = 1'b0;
    timeout  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && issue_hit) state_d = ISSUE;
      end
      ISSUE: begin
        ciStart = 1'b1;
        if (ciDone) begin
          capture = 1'b1;
          state_d = OUT;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ciDone) begin
          capture = 1'b1;
          state_d = OUT;
        end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        outValid = 1'b1;
        if (outReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      run_q    <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      top_l    <= '0;
      top_m    <= '0;
      mid_l    <= '0;
      mid_m    <= '0;
      bot_l    <= '0;
      bot_m    <= '0;
      ci_a_q   <= '0;
      ci_b_q   <= '0;
      wait_cnt <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (accept) begin
        if (cur_col == AW'(LINE_WIDTH - 1)) begin
          col_q <= '0;
          row_q <= (cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1;
        end else begin
          col_q <= cur_col + 1'b1;
          row_q <= cur_row;
        end
        top_l <= top_m;
        top_m <= rd_top;
        mid_l <= mid_m;
        mid_m <= rd_mid;
        bot_l <= bot_m;
        bot_m <= inPixel;
        if (issue_hit) begin
          ci_a_q <= ops.value_a;
          ci_b_q <= ops.value_b;
        end
      end
      wait_cnt <= (state_q == WAIT) ? wait_cnt + 1'b1 : '0;
      if (capture)      out_q <= result_pixel;
      else if (timeout) out_q <= '0;
      if (timeout)             err_q <= 1'b1;
      else if (accept && sof)  err_q <= 1'b0;
    end
  end

endmodule
